// File: rtl/four_nor_tester_pkg.sv
// Shared types, constants and the golden NOR-chain model for four_nor_tester.
package four_nor_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int VEC_COUNT = 16;
  localparam int VEC_W     = 4;
  localparam int CNT_W     = 4;
  localparam int ERR_W     = 5;

  // Expected chain node values for one stimulus vector.
  typedef struct packed {
    logic e;
    logic f;
    logic g;
  } chain_t;

  // Golden chain: vec[3]=A, vec[2]=B, vec[1]=C, vec[0]=D.
  function automatic chain_t golden(input logic [VEC_W-1:0] vec);
    chain_t r;
    r.e = ~(vec[3] | vec[2]);
    r.f = ~(r.e | vec[1]);
    r.g = ~(r.f | vec[0]);
    return r;
  endfunction

endpackage

// File: rtl/four_nor_tester_settle_counter.sv
// Loadable down-counter that times the dwell of each vector before it is checked.
module settle_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                    r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/four_nor_tester.sv
// Exhaustive 16-vector tester for a 4-input NOR chain with mismatch tally.
module four_nor_tester
  import four_nor_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail
);

  // Counter is loaded with N-1 so SETTLE lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(VEC_COUNT - 1);
  localparam logic [ERR_W-1:0] MAX_ERR  = ERR_W'(VEC_COUNT);

  state_t             r_state, w_next;
  logic [VEC_W-1:0]   r_vec;
  logic [ERR_W-1:0]   r_err;
  logic [VEC_W-1:0]   r_ff;
  logic               r_pass;
  logic               w_load, w_dec, w_zero, w_mismatch, w_drive;
  chain_t             w_gold;

  assign w_load = (r_state == ST_IDLE && start) ||
                  (r_state == ST_CHECK && r_vec != LAST_VEC);
  assign w_dec  = (r_state == ST_SETTLE);

  settle_counter #(.W(CNT_W)) u_settle (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_gold     = golden(r_vec);
  assign w_mismatch = ({E, F, G} != w_gold);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start)  w_next = ST_SETTLE;
      ST_SETTLE: if (w_zero) w_next = ST_CHECK;
      ST_CHECK:  w_next = (r_vec == LAST_VEC) ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Run bookkeeping: vector index, mismatch tally, first failure, verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_ff   <= '0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_vec  <= '0;
          r_err  <= '0;
          r_ff   <= '0;
          r_pass <= 1'b0;
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            if (r_err != MAX_ERR) r_err <= r_err + 1'b1;
            if (r_err == '0)      r_ff  <= r_vec;
          end
          // Verdict includes this last vector's own mismatch.
          if (r_vec != LAST_VEC) r_vec  <= r_vec + 1'b1;
          else                   r_pass <= (r_err == '0) && !w_mismatch;
        end
        default: ;
      endcase
    end
  end

  // Outputs: vector driven only while a vector is being exercised.
  always_comb begin
    w_drive      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    {A, B, C, D} = w_drive ? r_vec : '0;
    busy         = w_drive;
    done         = (r_state == ST_DONE);
  end

  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_four_nor_tester.sv
// Bench: two testers (default dwell and dwell=1) against a timeline model.
module tb_four_nor_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1;
  logic       a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0;
  logic       a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [3:0] ff0, ff1;

  int         checks = 0;
  int         errors = 0;
  int         mode   = 0;           // 0 good, 1 G stuck 0, 2 E stuck 1, 3 random faults
  logic [2:0] fmask [16];

  function automatic logic [2:0] gold(input int v);
    logic a, b, c, d, e, f, g;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    e = ~(a | b); f = ~(e | c); g = ~(f | d);
    return {e, f, g};
  endfunction

  function automatic logic [2:0] chain(input int md, input int v);
    logic [2:0] r;
    r = gold(v);
    case (md)
      1:       r[0] = 1'b0;
      2:       r[2] = 1'b1;
      3:       r    = r ^ fmask[v];
      default: ;
    endcase
    return r;
  endfunction

  assign {e0, f0, g0} = chain(mode, int'({a0, b0, c0, d0}));
  assign {e1, f1, g1} = gold(int'({a1, b1, c1, d1}));

  four_nor_tester dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_fail(ff0)
  );

  four_nor_tester #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_fail(ff1)
  );

  // Model: t = cycles since accepted start (-1 idle); vector v is checked in cycle (v+1)*(S+1).
  int S [2]      = '{2, 1};
  int t [2]      = '{-1, -1};
  int m_err [2]  = '{0, 0};
  int m_ff [2]   = '{0, 0};
  bit m_pass [2] = '{0, 0};
  bit armed      = 0;

  always @(posedge clk) begin
    armed = 1;
    for (int d = 0; d < 2; d++) begin
      int per, v;
      bit bad;
      per = S[d] + 1;
      if (!rst_n) begin
        t[d] = -1; m_err[d] = 0; m_ff[d] = 0; m_pass[d] = 0;
      end else if (t[d] < 0) begin
        if ((d == 0) ? start0 : start1) begin
          t[d] = 1; m_err[d] = 0; m_ff[d] = 0; m_pass[d] = 0;
        end
      end else begin
        if (t[d] % per == 0 && t[d] <= 16 * per) begin
          v   = t[d] / per - 1;
          bad = (d == 0) ? (chain(mode, v) != gold(v)) : 1'b0;
          if (bad) begin
            if (m_err[d] == 0) m_ff[d] = v;
            m_err[d]++;
          end
        end
        if (t[d] == 16 * per) m_pass[d] = (m_err[d] == 0);
        if (t[d] == 16 * per + 1) t[d] = -1;
        else                      t[d]++;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        int per, vec;
        bit eb, ed;
        logic [15:0] ex, ac;
        per = S[d] + 1;
        eb  = (t[d] >= 1) && (t[d] <= 16 * per);
        ed  = (t[d] == 16 * per + 1);
        vec = eb ? (t[d] - 1) / per : 0;
        ex  = {eb, ed, m_pass[d], 5'(m_err[d]), 4'(m_ff[d]), 4'(vec)};
        ac  = (d == 0) ? {busy0, done0, pass0, err0, ff0, a0, b0, c0, d0}
                       : {busy1, done1, pass1, err1, ff1, a1, b1, c1, d1};
        checks++;
        if (ac !== ex) begin
          errors++;
          $display("FAIL model_cycle dut%0d t=%0d act=%h exp=%h", d, t[d], ac, ex);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Pulse (or hold/noise) start on dut0 and count cycles until done.
  task automatic run0(input bit hold, input bit noise, output int cyc);
    start0 = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start0 = hold ? 1'b1 : (noise ? ($urandom % 3 == 0) : 1'b0);
      if (done0) break;
      if (cyc > 300) begin chk("run0_timeout", cyc, 0); break; end
    end
    start0 = 1'b0;
  endtask

  initial begin
    int cyc, ecnt, eff;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 16; i++) fmask[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_outs", int'({a0, b0, c0, d0, done0, pass0}), 0);
    chk("reset_err", err0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0; run0(0, 0, cyc);
    chk("good_latency", cyc, 49);
    @(negedge clk);
    chk("good_pass", pass0, 1); chk("good_err", err0, 0); chk("good_ff", ff0, 0);

    mode = 1; run0(0, 0, cyc);
    @(negedge clk);
    chk("g0_err", err0, 5); chk("g0_ff", ff0, 0); chk("g0_pass", pass0, 0);

    mode = 2; run0(0, 0, cyc);
    @(negedge clk);
    chk("e1_err", err0, 12); chk("e1_ff", ff0, 4); chk("e1_pass", pass0, 0);

    // Start held high: one run, no restart from DONE, new run only from IDLE.
    mode = 0; run0(1, 0, cyc);
    chk("hold_latency", cyc, 49);
    start0 = 1'b1;
    @(negedge clk); chk("hold_idle_after_done", busy0, 0);
    @(negedge clk); chk("hold_restart", busy0, 1);
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 300) begin @(negedge clk); cyc++; end
    chk("hold_second_latency", cyc, 49);
    @(negedge clk);

    // Reset while vector 7 is on the bus.
    mode = 1; start0 = 1'b1; cyc = 0;
    while (cyc < 23) begin @(negedge clk); cyc++; start0 = 1'b0; end
    chk("mid_vec", int'({a0, b0, c0, d0}), 7);
    chk("mid_err", err0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset_busy", busy0, 0);
    chk("mid_reset_err", err0, 0);
    chk("mid_reset_outs", int'({a0, b0, c0, d0, done0, pass0, ff0}), 0);
    mode = 0; run0(0, 0, cyc);
    chk("post_reset_latency", cyc, 49);
    @(negedge clk);
    chk("post_reset_pass", pass0, 1);

    // Random fault patterns with spurious start pulses during the run.
    for (int r = 0; r < 6; r++) begin
      ecnt = 0; eff = 0;
      for (int i = 0; i < 16; i++) begin
        fmask[i] = ($urandom % 4 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        if (fmask[i] != 0) begin
          if (ecnt == 0) eff = i;
          ecnt++;
        end
      end
      mode = 3;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run0(0, 1, cyc);
      chk("rand_latency", cyc, 49);
      @(negedge clk);
      chk("rand_err", err0, ecnt); chk("rand_ff", ff0, eff); chk("rand_pass", pass0, int'(ecnt == 0));
    end

    // Single-cycle dwell instance.
    start1 = 1'b1; cyc = 0;
    while (1) begin
      @(negedge clk); cyc++; start1 = 1'b0;
      if (done1) break;
      if (cyc > 300) begin chk("run1_timeout", cyc, 0); break; end
    end
    chk("s1_latency", cyc, 33);
    @(negedge clk);
    chk("s1_pass", pass1, 1); chk("s1_err", err1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
